// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch front end: FSM encoding and
// address defaults.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] DEF_RESET_PC     = 32'h0000_1000;
  localparam logic [31:0] DEF_EXCEPTION_PC = 32'h0000_2000;
  localparam int          INSTR_BYTES      = 4;

endpackage

// File: rtl/fetch_unit_queue.sv
// Circular FIFO of {pc, instruction} entries with a registered head so the
// decode side sees stable values, including while the queue is empty.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic [WIDTH-1:0]        push_data,
  input  logic                    pop,
  input  logic                    flush,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    head_valid,
  output logic [WIDTH-1:0]        head_data
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_pop;
  logic [PTR_W-1:0] rd_nxt;
  logic [PTR_W:0]   remain;

  assign do_pop     = pop && (count != '0);
  assign rd_nxt     = rd_ptr + PTR_W'(do_pop);
  assign remain     = count - (PTR_W + 1)'(do_pop);
  assign head_valid = (count != '0);

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr <= rd_nxt;
      count  <= remain + (PTR_W + 1)'(push);
    end
  end

  // Head tracks the entry that will be oldest after this cycle's pop/push;
  // when nothing older survives, the pushed entry becomes the head.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
    if (!flush) begin
      if (remain != '0) head_data <= mem[rd_nxt];
      else if (push)    head_data <= push_data;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: owns the PC, issues one outstanding I-cache request at a
// time, buffers fetched words with their PC, handles redirect and exceptions.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int               XLEN         = 32,
  parameter int               INSTR_WIDTH  = 32,
  parameter int               QUEUE_DEPTH  = 4,
  parameter logic [XLEN-1:0]  RESET_PC     = XLEN'(DEF_RESET_PC),
  parameter logic [XLEN-1:0]  EXCEPTION_PC = XLEN'(DEF_EXCEPTION_PC)
) (
  input  logic                           clk,
  input  logic                           reset,
  output logic                           icache_access,
  output logic [XLEN-1:0]                icache_address,
  input  logic                           icache_data_ready,
  input  logic [INSTR_WIDTH-1:0]         icache_data_out,
  input  logic                           redirect_valid,
  input  logic [XLEN-1:0]                redirect_pc,
  input  logic                           exception_valid,
  input  logic [XLEN-1:0]                exception_pc,
  output logic [XLEN-1:0]                rm0_out,
  output logic                           dec_valid,
  output logic [INSTR_WIDTH-1:0]         dec_instruction,
  output logic [XLEN-1:0]                dec_pc,
  input  logic                           dec_stall,
  output logic [$clog2(QUEUE_DEPTH):0]   queue_count
);

  localparam int                CNT_W    = $clog2(QUEUE_DEPTH) + 1;
  localparam int                ENTRY_W  = XLEN + INSTR_WIDTH;
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(QUEUE_DEPTH);

  fetch_state_e     state;
  fetch_state_e     state_nxt;
  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  req_addr;
  logic             flush;
  logic [XLEN-1:0]  flush_pc;
  logic             issue;
  logic             push;
  logic             pop;
  logic [ENTRY_W-1:0] head_data;

  assign flush    = redirect_valid || exception_valid;
  assign flush_pc = exception_valid ? EXCEPTION_PC : redirect_pc;
  assign pop      = dec_valid && !dec_stall;

  // Request lines come straight from registers, so data_ready never reaches
  // icache_access combinationally.
  assign icache_access  = (state == WAIT) || (state == DISCARD);
  assign icache_address = req_addr;

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    push      = 1'b0;
    case (state)
      RUN: begin
        if ((queue_count < FULL_CNT) && !flush) begin
          issue     = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (icache_data_ready) begin
          push      = !flush;
          state_nxt = RUN;
        end else if (flush) begin
          state_nxt = DISCARD;
        end
      end
      DISCARD: begin
        if (icache_data_ready) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= RUN;
      pc      <= RESET_PC;
      rm0_out <= '0;
    end else begin
      state <= state_nxt;
      if (flush)     pc <= flush_pc;
      else if (push) pc <= pc + XLEN'(INSTR_BYTES);
      if (exception_valid) rm0_out <= exception_pc;
    end
  end

  // Address is latched at issue so a flush can move pc while the old
  // request is still being held in DISCARD.
  always_ff @(posedge clk) begin
    if (issue) req_addr <= pc;
  end

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_queue (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_data  ({req_addr, icache_data_out}),
    .pop        (pop),
    .flush      (flush),
    .count      (queue_count),
    .head_valid (dec_valid),
    .head_data  (head_data)
  );

  assign dec_pc          = head_data[ENTRY_W-1 -: XLEN];
  assign dec_instruction = head_data[INSTR_WIDTH-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: transaction-level model of the fetch
// queue and request stream, a responsive cache stub, directed and random phases.
module tb_fetch_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        icache_access;
  logic [31:0] icache_address;
  logic        icache_data_ready = 1'b0;
  logic [31:0] icache_data_out = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        exception_valid = 1'b0;
  logic [31:0] exception_pc = '0;
  logic [31:0] rm0_out;
  logic        dec_valid;
  logic [31:0] dec_instruction;
  logic [31:0] dec_pc;
  logic        dec_stall = 1'b0;
  logic [2:0]  queue_count;

  fetch_unit dut (
    .clk               (clk),
    .reset             (reset),
    .icache_access     (icache_access),
    .icache_address    (icache_address),
    .icache_data_ready (icache_data_ready),
    .icache_data_out   (icache_data_out),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .exception_valid   (exception_valid),
    .exception_pc      (exception_pc),
    .rm0_out           (rm0_out),
    .dec_valid         (dec_valid),
    .dec_instruction   (dec_instruction),
    .dec_pc            (dec_pc),
    .dec_stall         (dec_stall),
    .queue_count       (queue_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } entry_t;

  int checks = 0;
  int failures = 0;

  // Model state: queue contents, next fetch pc, outstanding request.
  entry_t      m_q[$];
  logic [31:0] m_pc, m_rm0, m_addr;
  bit          m_out, m_disc;
  int          m_size0;
  bit          m_out0, m_flush;
  entry_t      m_e;

  logic [31:0] req_log[$];
  logic [31:0] pop_log[$];
  bit          chk_en = 1'b0;
  bit          prev_acc = 1'b0;

  int lat_fix = 2;
  bit lat_rand = 1'b0;
  int ccnt = 0;
  bit cbusy = 1'b0;
  int stall_bias = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] req_at(input int k);
    return (req_log.size() > k) ? req_log[k] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] pop_at(input int k);
    return (pop_log.size() > k) ? pop_log[k] : 32'hDEAD_BEEF;
  endfunction

  // Reference model advanced at every active edge.
  initial forever begin
    @(posedge clk);
    if (!reset) begin
      m_q.delete();
      m_pc = 32'h1000; m_rm0 = '0; m_out = 1'b0; m_disc = 1'b0;
    end else begin
      if (dec_valid && !dec_stall) pop_log.push_back(dec_pc);
      m_size0 = m_q.size();
      m_out0  = m_out;
      m_flush = exception_valid || redirect_valid;
      if (m_q.size() > 0 && !dec_stall) void'(m_q.pop_front());
      if (m_out && icache_data_ready) begin
        m_out = 1'b0;
        if (!m_disc && !m_flush) begin
          m_e.pc = m_addr; m_e.ins = icache_data_out;
          m_q.push_back(m_e);
          m_pc = m_pc + 32'd4;
        end
      end
      if (m_flush) begin
        m_q.delete();
        m_pc = exception_valid ? 32'h2000 : redirect_pc;
        if (exception_valid) m_rm0 = exception_pc;
        if (m_out) m_disc = 1'b1;
      end
      if (!m_out0 && m_size0 < DEPTH && !m_flush) begin
        m_out = 1'b1; m_addr = m_pc; m_disc = 1'b0;
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("queue_count", 32'(queue_count), 32'(m_q.size()));
      chk("dec_valid", 32'(dec_valid), 32'(m_q.size() != 0));
      if (m_q.size() != 0) begin
        chk("dec_pc", dec_pc, m_q[0].pc);
        chk("dec_instruction", dec_instruction, m_q[0].ins);
      end
      chk("rm0_out", rm0_out, m_rm0);
      chk("icache_access", 32'(icache_access), 32'(m_out));
      if (m_out) chk("icache_address", icache_address, m_addr);
      if (icache_access && !prev_acc) req_log.push_back(icache_address);
    end
    prev_acc = icache_access;
  end

  // Cache stub: answers each request after a fixed or random latency.
  initial forever begin
    @(negedge clk);
    icache_data_ready = 1'b0;
    if (icache_access) begin
      if (!cbusy) begin
        cbusy = 1'b1;
        ccnt  = lat_rand ? int'($urandom_range(3, 0)) : lat_fix;
      end
      if (ccnt == 0) begin
        icache_data_ready = 1'b1;
        icache_data_out   = $urandom;
        cbusy = 1'b0;
      end else begin
        ccnt--;
      end
    end else begin
      cbusy = 1'b0;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    req_log.delete();
    pop_log.delete();
  endtask

  task automatic wait_reqs(input int n, input int budget);
    int c = 0;
    while (req_log.size() < n && c < budget) begin tick(); c++; end
    chk("req_wait", 32'(req_log.size() >= n), 32'd1);
  endtask

  task automatic wait_pops(input int n, input int budget);
    int c = 0;
    while (pop_log.size() < n && c < budget) begin tick(); c++; end
    chk("pop_wait", 32'(pop_log.size() >= n), 32'd1);
  endtask

  task automatic wait_access(input int budget);
    int c = 0;
    while (!icache_access && c < budget) begin tick(); c++; end
    chk("access_wait", 32'(icache_access), 32'd1);
  endtask

  initial begin
    int n;
    // Reset state
    tick();
    chk("rst_access", 32'(icache_access), 32'd0);
    chk("rst_count", 32'(queue_count), 32'd0);
    chk("rst_dec_valid", 32'(dec_valid), 32'd0);
    chk("rst_rm0", rm0_out, 32'd0);
    chk_en = 1'b1;
    reset = 1'b1;
    req_log.delete();

    // Sequential fetch from the reset vector, 3-cycle cache
    wait_reqs(3, 60);
    chk("seq_req0", req_at(0), 32'h1000);
    chk("seq_req1", req_at(1), 32'h1004);
    chk("seq_req2", req_at(2), 32'h1008);
    wait_pops(2, 60);
    chk("seq_pop0", pop_at(0), 32'h1000);
    chk("seq_pop1", pop_at(1), 32'h1004);
    chk("seq_rm0", rm0_out, 32'd0);

    // Back-pressure fills the queue, release drains it in order
    dec_stall = 1'b1;
    apply_reset();
    repeat (40) tick();
    chk("full_count", 32'(queue_count), 32'd4);
    chk("full_access", 32'(icache_access), 32'd0);
    chk("full_reqs", 32'(req_log.size()), 32'd4);
    dec_stall = 1'b0;
    wait_pops(4, 40);
    for (int i = 0; i < 4; i++) chk("drain_pop", pop_at(i), 32'h1000 + 32'(4 * i));
    wait_reqs(5, 40);
    chk("resume_req", req_at(4), 32'h1010);

    // Redirect while a request is outstanding
    apply_reset();
    wait_reqs(3, 60);
    redirect_valid = 1'b1;
    redirect_pc = 32'h1400;
    tick();
    redirect_valid = 1'b0;
    chk("redir_count", 32'(queue_count), 32'd0);
    chk("redir_dec_valid", 32'(dec_valid), 32'd0);
    chk("redir_held_access", 32'(icache_access), 32'd1);
    chk("redir_held_addr", icache_address, 32'h1008);
    n = req_log.size();
    wait_reqs(n + 1, 40);
    chk("redir_new_req", req_at(n), 32'h1400);

    // Exception wins over a simultaneous redirect
    exception_valid = 1'b1;
    exception_pc = 32'h1008;
    redirect_valid = 1'b1;
    redirect_pc = 32'h1400;
    tick();
    exception_valid = 1'b0;
    redirect_valid = 1'b0;
    chk("exc_rm0", rm0_out, 32'h1008);
    chk("exc_count", 32'(queue_count), 32'd0);
    n = req_log.size();
    wait_reqs(n + 1, 40);
    chk("exc_new_req", req_at(n), 32'h2000);

    // Reset in the middle of an outstanding request
    wait_access(20);
    reset = 1'b0;
    tick();
    chk("midrst_access", 32'(icache_access), 32'd0);
    chk("midrst_count", 32'(queue_count), 32'd0);
    chk("midrst_rm0", rm0_out, 32'd0);
    reset = 1'b1;
    req_log.delete();
    wait_reqs(1, 20);
    chk("midrst_req", req_at(0), 32'h1000);

    // PC wraps past the top of the address space
    dec_stall = 1'b1;
    apply_reset();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    tick();
    redirect_valid = 1'b0;
    req_log.delete();
    repeat (40) tick();
    chk("wrap_req0", req_at(0), 32'hFFFF_FFF8);
    chk("wrap_req1", req_at(1), 32'hFFFF_FFFC);
    chk("wrap_req2", req_at(2), 32'h0000_0000);
    chk("wrap_req3", req_at(3), 32'h0000_0004);
    chk("wrap_head", dec_pc, 32'hFFFF_FFF8);
    dec_stall = 1'b0;

    // Random traffic against the model
    lat_rand = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (i % 64 == 0) stall_bias = int'($urandom_range(3, 0));
      dec_stall       = (int'($urandom_range(3, 0)) < stall_bias);
      redirect_valid  = ($urandom_range(24, 0) == 0);
      redirect_pc     = ($urandom_range(7, 0) == 0) ? 32'hFFFF_FFF0 : ($urandom & ~32'h3);
      exception_valid = ($urandom_range(49, 0) == 0);
      exception_pc    = $urandom;
      reset           = ($urandom_range(399, 0) != 0);
      tick();
    end
    reset = 1'b1;
    redirect_valid = 1'b0;
    exception_valid = 1'b0;
    repeat (5) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
